// File: rtl/shift_sched_pkg.sv
// Shared types and defaults for the shift-register scheduler.
// Holds the FSM state enum and the default WIDTH/NREQ values.
package shift_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } sched_state_t;

  localparam int WIDTH_DEF = 8;
  localparam int NREQ_DEF  = 2;

endpackage

// File: rtl/shift_sched_dp.sv
// Load/shift register with bit counter (and parity accumulator when
// SHIFT_SCHED_PARITY_EN is defined); MSB-first serialiser datapath.
// Ports: Clk, Rst (sync, active-high), load, shift, din, len ->
//        msb, cnt_is_one, parity (SHIFT_SCHED_PARITY_EN only).
module shift_sched_dp
  import shift_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LENW  = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic [LENW-1:0]  len,
  output logic             msb,
  output logic             cnt_is_one
`ifdef SHIFT_SCHED_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [LENW-1:0]  cnt_q, cnt_d;
  logic [LENW-1:0]  len_eff;

  // Zero or oversize lengths both mean a full word.
  always_comb begin
    len_eff = len;
    if (len == '0 || len > LENW'(WIDTH)) begin
      len_eff = LENW'(WIDTH);
    end
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = din;
      cnt_d = len_eff;
    end else if (shift) begin
      sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - LENW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb        = sr_q[WIDTH-1];
  assign cnt_is_one = (cnt_q == LENW'(1));

`ifdef SHIFT_SCHED_PARITY_EN
  logic par_q, par_d;

  // Accumulates exactly the bits that leave on accepted beats.
  always_comb begin
    par_d = par_q;
    if (load) begin
      par_d = 1'b0;
    end else if (shift) begin
      par_d = par_q ^ sr_q[WIDTH-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity = par_q;
`endif

endmodule

// File: rtl/shift_reg_sched.sv
// Round-robin scheduler sharing one MSB-first shift register among NREQ
// requesters; optional even-parity beat under SHIFT_SCHED_PARITY_EN.
// Ports: Clk, Rst (sync, active-high), req_valid/req_data/req_len ->
//        req_ready; ser_out/ser_valid/ser_last <- ser_ready; busy, grant_id.
module shift_reg_sched
  import shift_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic [NREQ-1:0]                     req_valid,
  input  logic [NREQ*WIDTH-1:0]               req_data,
  input  logic [NREQ*$clog2(WIDTH+1)-1:0]     req_len,
  output logic [NREQ-1:0]                     req_ready,
  output logic                                ser_out,
  output logic                                ser_valid,
  output logic                                ser_last,
  input  logic                                ser_ready,
  output logic                                busy,
  output logic [$clog2(NREQ)-1:0]             grant_id
);

  localparam int LENW = $clog2(WIDTH + 1);
  localparam int GW   = $clog2(NREQ);

  sched_state_t     state_q, state_d;
  logic [GW-1:0]    rr_q, rr_d;
  logic [GW-1:0]    gid_q, gid_d;
  logic [GW-1:0]    gnt, idx;
  logic             hit;
  logic [WIDTH-1:0] din_sel;
  logic [LENW-1:0]  len_sel;
  logic             load, shift;
  logic             msb, cnt_is_one;
`ifdef SHIFT_SCHED_PARITY_EN
  logic             parity;
`endif

  // First valid requester at or after rr_q, wrapping.
  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = GW'((int'(rr_q) + k) % NREQ);
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        gnt = idx;
      end
    end
  end

  always_comb begin
    din_sel = '0;
    len_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == gnt) begin
        din_sel = req_data[i*WIDTH +: WIDTH];
        len_sel = req_len[i*LENW +: LENW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gid_d     = gid_q;
    req_ready = '0;
    load      = 1'b0;
    shift     = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // No accept strobe while reset is held: the word would be lost.
        if (hit && !Rst) begin
          req_ready[gnt] = 1'b1;
          load           = 1'b1;
          gid_d          = gnt;
          rr_d           = (gnt == GW'(NREQ-1)) ? '0 : gnt + GW'(1);
          state_d        = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = msb;
`ifndef SHIFT_SCHED_PARITY_EN
        ser_last  = cnt_is_one;
`endif
        shift     = ser_ready;
        if (ser_ready && cnt_is_one) begin
`ifdef SHIFT_SCHED_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef SHIFT_SCHED_PARITY_EN
      PARITY: begin
        ser_valid = 1'b1;
        ser_out   = parity;
        ser_last  = 1'b1;
        if (ser_ready) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = gid_q;

  shift_sched_dp #(
    .WIDTH(WIDTH),
    .LENW (LENW)
  ) u_dp (
    .Clk       (Clk),
    .Rst       (Rst),
    .load      (load),
    .shift     (shift),
    .din       (din_sel),
    .len       (len_sel),
    .msb       (msb),
    .cnt_is_one(cnt_is_one)
`ifdef SHIFT_SCHED_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

endmodule

// File: tb/tb_shift_reg_sched.sv
// Scoreboard bench for shift_reg_sched: frame-level reference model
// predicts grants and beats; a monitor compares each presented beat.
module tb_shift_reg_sched;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [7:0]  req_len = '0;
  logic [1:0]  req_ready;
  logic        ser_out, ser_valid, ser_last;
  logic        ser_ready = 1'b0;
  logic        busy;
  logic [0:0]  grant_id;

  shift_reg_sched #(.WIDTH(8), .NREQ(2)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_len  (req_len),
    .req_ready(req_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_last (ser_last),
    .ser_ready(ser_ready),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic b;
    logic last;
    logic id;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] w_data[2];
  logic [3:0] w_len[2];
  bit         taken[2];
  int         rr_m = 0;
  bit         just_granted = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         g_m, i_m;
  logic [1:0] exp_rdy;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Frame = effective-length MSB-first bits of the word, plus parity.
  task automatic push_frame(input int g);
    int    L;
    logic  p;
    beat_t e;
    L = (w_len[g] == 0 || w_len[g] > 8) ? 8 : int'(w_len[g]);
    p = 1'b0;
    for (int b = 0; b < L; b++) begin
      e.b = w_data[g][7-b];
`ifdef SHIFT_SCHED_PARITY_EN
      e.last = 1'b0;
`else
      e.last = (b == L - 1);
`endif
      e.id = g[0];
      p = p ^ e.b;
      sb.push_back(e);
    end
`ifdef SHIFT_SCHED_PARITY_EN
    e.b = p;
    e.last = 1'b1;
    e.id = g[0];
    sb.push_back(e);
`endif
  endtask

  // Reference model: a grant is due whenever no frame is outstanding.
  initial forever begin
    @(negedge Clk);
    just_granted = 0;
    if (Rst) begin
      sb.delete();
      rr_m = 0;
      chk("ready_in_rst", req_ready, 0);
    end else begin
      chk("busy", busy, sb.size() != 0);
      g_m = -1;
      if (sb.size() == 0) begin
        for (int k = 0; k < 2; k++) begin
          i_m = (rr_m + k) % 2;
          if (g_m < 0 && req_valid[i_m]) g_m = i_m;
        end
      end
      exp_rdy = (g_m < 0) ? 2'b00 : 2'(1 << g_m);
      chk("req_ready", req_ready, exp_rdy);
      if (g_m >= 0) begin
        push_frame(g_m);
        rr_m = (g_m + 1) % 2;
        taken[g_m] = 1;
        just_granted = 1;
      end
    end
  end

  // Monitor: compares every presented beat; holds it until accepted.
  initial forever begin
    @(negedge Clk);
    #1;
    if (!Rst) begin
      if (sb.size() == 0 || just_granted) begin
        chk("ser_valid_idle", ser_valid, 0);
      end else begin
        chk("ser_valid", ser_valid, 1);
        chk("ser_out", ser_out, sb[0].b);
        chk("ser_last", ser_last, sb[0].last);
        chk("grant_id", grant_id, sb[0].id);
        if (ser_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic pack();
    req_data = {w_data[1], w_data[0]};
    req_len  = {w_len[1], w_len[0]};
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_taken(input int i, input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge Clk);
      #2;
      if (taken[i]) begin
        ok = 1;
        break;
      end
    end
    chk("grant_wait", ok, 1);
    taken[i] = 0;
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge Clk);
      #2;
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("drain", ok, 1);
  endtask

  initial begin
    w_data[0] = '0; w_data[1] = '0;
    w_len[0] = '0; w_len[1] = '0;
    pack();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_ser_last", ser_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    step();
    Rst = 1'b0;

    // Single request, A5 full length.
    w_data[0] = 8'hA5; w_len[0] = 4'd8; pack();
    req_valid = 2'b01; ser_ready = 1'b1;
    wait_taken(0, 20);
    step();
    req_valid = 2'b00;
    drain(30);

    // Round robin with both requesters always valid.
    step();
    w_data[0] = 8'hFF; w_data[1] = 8'h00;
    w_len[0] = 4'd8; w_len[1] = 4'd8; pack();
    req_valid = 2'b11;
    repeat (45) step();
    req_valid = 2'b00;
    drain(30);

    // Short frame with a 4-cycle stall on beat 2.
    step();
    w_data[1] = 8'hC0; w_len[1] = 4'd3; pack();
    req_valid = 2'b10;
    wait_taken(1, 20);
    step();
    req_valid = 2'b00;
    step();
    ser_ready = 1'b0;
    repeat (4) step();
    ser_ready = 1'b1;
    drain(30);

    // Reset during beat 4; next grant must go to requester 0.
    step();
    w_data[0] = 8'h5A; w_len[0] = 4'd8; pack();
    req_valid = 2'b01;
    wait_taken(0, 20);
    step();
    req_valid = 2'b11;
    repeat (3) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    @(negedge Clk);
    #2;
    chk("abort_ser_valid", ser_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_next_grant", req_ready, 2'b01);
    taken[0] = 0;
    step();
    req_valid = 2'b00;
    drain(30);

`ifdef SHIFT_SCHED_PARITY_EN
    step();
    w_data[0] = 8'h07; w_len[0] = 4'd8; pack();
    req_valid = 2'b01;
    wait_taken(0, 20);
    step();
    req_valid = 2'b00;
    drain(30);
`endif

    // Randomized traffic, backpressure, lengths and rare resets.
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (taken[i]) begin
          w_data[i] = 8'($urandom);
          w_len[i] = 4'($urandom);
          taken[i] = 0;
        end
        req_valid[i] = ($urandom_range(0, 3) != 0);
      end
      pack();
      ser_ready = ($urandom_range(0, 3) != 0);
      Rst = ($urandom_range(0, 199) == 0);
    end
    step();
    Rst = 1'b0;
    req_valid = 2'b00;
    ser_ready = 1'b1;
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
